// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and width defaults for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_WD_DEF         = 32;
  localparam int unsigned DATA_WD_DEF         = 32;
  localparam int unsigned MAX_DATA_STREAK_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between inst and data requesters, with a data-streak limit
// so a continuously requesting data side cannot starve instruction fetch.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   grant_en_i,
  input  logic   inst_req_i,
  input  logic   data_req_i,
  output logic   grant_o,
  output owner_e owner_o
);

  // A zero limit still needs a one-bit counter; it then simply never leaves 0.
  localparam int unsigned SW = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

  logic [SW-1:0] streak_q, streak_d;
  logic          inst_turn;

  // Pick the winner and compute the streak update for this grant.
  always_comb begin
    inst_turn = inst_req_i && (streak_q == STREAK_MAX);
    grant_o   = grant_en_i && (inst_req_i || data_req_i);
    owner_o   = (data_req_i && !inst_turn) ? DATA : INST;
    streak_d  = streak_q;
    if (grant_o) begin
      if ((owner_o == INST) || !inst_req_i) begin
        streak_d = '0;
      end else if (streak_q != STREAK_MAX) begin
        streak_d = streak_q + 1'b1;
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master (inst/data) to one-slave memory port arbiter with a single
// outstanding transaction: accept in IDLE, address phase in REQ, wait for
// the response in RESP.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WD         = ADDR_WD_DEF,
  parameter int unsigned DATA_WD         = DATA_WD_DEF,
  parameter int unsigned MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inst_req,
  input  logic [ADDR_WD-1:0] inst_addr,
  output logic               inst_addr_ok,
  output logic               inst_data_ok,
  output logic [DATA_WD-1:0] inst_rdata,
  input  logic               data_req,
  input  logic               data_wr,
  input  logic [3:0]         data_wstrb,
  input  logic [ADDR_WD-1:0] data_addr,
  input  logic [DATA_WD-1:0] data_wdata,
  output logic               data_addr_ok,
  output logic               data_data_ok,
  output logic [DATA_WD-1:0] data_rdata,
  output logic               mem_req,
  output logic               mem_wr,
  output logic [3:0]         mem_wstrb,
  output logic [ADDR_WD-1:0] mem_addr,
  output logic [DATA_WD-1:0] mem_wdata,
  input  logic               mem_addr_ok,
  input  logic               mem_data_ok,
  input  logic [DATA_WD-1:0] mem_rdata
);

  arb_state_e         state_q, state_d;
  owner_e             owner_q, owner_d;
  logic [ADDR_WD-1:0] addr_q, addr_d;
  logic               wr_q, wr_d;
  logic [3:0]         wstrb_q, wstrb_d;
  logic [DATA_WD-1:0] wdata_q, wdata_d;
  logic               grant;
  owner_e             grant_owner;

  mem_arb_pick #(
    .MAX_DATA_STREAK(MAX_DATA_STREAK)
  ) u_pick (
    .clk       (clk),
    .reset     (reset),
    .grant_en_i(state_q == IDLE),
    .inst_req_i(inst_req),
    .data_req_i(data_req),
    .grant_o   (grant),
    .owner_o   (grant_owner)
  );

  // Next-state, request latching and handshake pulses.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_req      = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d = grant_owner;
          state_d = REQ;
          if (grant_owner == DATA) begin
            data_addr_ok = 1'b1;
            addr_d       = data_addr;
            wr_d         = data_wr;
            wstrb_d      = data_wstrb;
            wdata_d      = data_wdata;
          end else begin
            // Fetches are reads; keep write fields quiet on the bus.
            inst_addr_ok = 1'b1;
            addr_d       = inst_addr;
            wr_d         = 1'b0;
            wstrb_d      = 4'h0;
            wdata_d      = '0;
          end
        end
      end
      REQ: begin
        mem_req = 1'b1;
        if (mem_addr_ok) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (mem_data_ok) begin
          state_d = IDLE;
          if (owner_q == DATA) begin
            data_data_ok = 1'b1;
          end else begin
            inst_data_ok = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus fields come straight from the latches; read data only shows with its data_ok.
  always_comb begin
    mem_wr     = wr_q;
    mem_wstrb  = wstrb_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    inst_rdata = inst_data_ok ? mem_rdata : '0;
    data_rdata = data_data_ok ? mem_rdata : '0;
  end

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= INST;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wstrb_q <= 4'h0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The module SHALL have parameter ADDR_WD, default 32, meaning address width of all ports.
REQ-002 The module SHALL have parameter DATA_WD, default 32, meaning data width of all ports.
REQ-003 The module SHALL have parameter MAX_DATA_STREAK, default 4, meaning consecutive data grants allowed while inst waits.
REQ-004 The module SHALL have these ports: clk  in  1  single clock, all logic on rising edge.
REQ-005 The module SHALL have these ports: reset  in  1  synchronous, active-high.
REQ-006 The module SHALL have these ports: inst_req in 1, inst_addr in ADDR_WD, inst_addr_ok out 1, inst_data_ok out 1, inst_rdata out DATA_WD; inst side is read-only.
REQ-007 The module SHALL have these ports: data_req in 1, data_wr in 1, data_wstrb in 4, data_addr in ADDR_WD, data_wdata in DATA_WD, data_addr_ok out 1, data_data_ok out 1, data_rdata out DATA_WD.
REQ-008 The module SHALL have these ports: mem_req out 1, mem_wr out 1, mem_wstrb out 4, mem_addr out ADDR_WD, mem_wdata out DATA_WD, mem_addr_ok in 1, mem_data_ok in 1, mem_rdata in DATA_WD.

Function
REQ-009 The arbiter SHALL implement states IDLE, REQ, RESP with at most one outstanding memory transaction.
REQ-010 In IDLE, if any *_req is high, the arbiter SHALL pulse the winner's *_addr_ok for one cycle, latch owner/addr/wr/wstrb/wdata, and go to REQ next cycle.
REQ-011 Winner selection SHALL be data over inst, except inst wins when inst_req=1 and streak==MAX_DATA_STREAK.
REQ-012 Streak SHALL increment (saturating at MAX_DATA_STREAK) on a data grant with inst_req=1, and clear on any inst grant or on a data grant with inst_req=0.
REQ-013 In REQ, mem_req SHALL be 1 with latched fields; on mem_addr_ok=1 the state SHALL go to RESP.
REQ-014 Inst grants SHALL drive mem_wr=0, mem_wstrb=4'h0, mem_wdata=0.
REQ-015 In RESP, on mem_data_ok=1 the owner's *_data_ok SHALL pulse that same cycle with *_rdata=mem_rdata, and state SHALL return to IDLE.
REQ-016 The non-owner's data_ok SHALL stay 0; mem_data_ok outside RESP SHALL be ignored.
REQ-017 *_rdata SHALL be mem_rdata when the matching data_ok is 1 and 0 otherwise.
REQ-018 Minimum turnaround SHALL be: accept T, mem_req T+1, data_ok T+2 (mem_addr_ok at T+1 and mem_data_ok at T+2), next accept T+3.
REQ-019 *_addr_ok SHALL never assert outside IDLE; requesters hold *_req until addr_ok.
REQ-020 Write responses SHALL also complete via mem_data_ok and pulse data_data_ok.

Reset
REQ-021 While reset=1 on a clock edge: state=IDLE, streak=0, owner=inst, latched fields=0.
REQ-022 All outputs SHALL be 0 in the cycle after reset, including mem_req and all addr_ok/data_ok.
REQ-023 Reset mid-REQ or mid-RESP SHALL abandon the transaction with no data_ok pulse generated for it.

Structure
REQ-024 A shared package SHALL hold the state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2), owner encoding (INST=1'b0, DATA=1'b1) and width defaults.
REQ-025 Winner selection plus streak counter SHALL be one sub-module, mem_arb_pick; FSM and latches SHALL stay in the top.

Verification
REQ-026 Bench SHALL check: after reset, inst_req=1 addr=0xbfc00000 only -> inst_addr_ok at T, mem_req/addr=0xbfc00000 at T+1, inst_data_ok with mem_rdata=0x02800000 at T+2.
REQ-027 Bench SHALL check: inst_req and data_req both 1, data_wr=1 addr=0x1c000010 wstrb=4'hf -> data granted first, mem_wr=1, inst granted next IDLE.
REQ-028 Bench SHALL check: both held continuously with streak=4 -> grants D,D,D,D,I,D, with streak clearing on the inst grant.
REQ-029 Bench SHALL check: mem_addr_ok delayed 3 cycles -> mem_req and fields stable throughout; no addr_ok to either side during the wait.
REQ-030 Bench SHALL check: reset asserted in RESP, then mem_data_ok=1 one cycle after reset -> no data_ok pulse, state IDLE.
REQ-031 Bench SHALL check: spurious mem_data_ok in IDLE -> ignored, no outputs change.
